// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: I-type funct3 encodings and arbiter limits.
// Imported by the shared-ALU arbiter and its round-robin picker.
package riscv_pkg;

  typedef enum logic [2:0] {
    ADDI  = 3'b000,
    SLLI  = 3'b001,
    SLTI  = 3'b010,
    SLTIU = 3'b011,
    XORI  = 3'b100,
    SRLI  = 3'b101,
    ORI   = 3'b110,
    ANDI  = 3'b111
  } i_func;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  localparam int IALU_ARB_MAX_REQ = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, with wrap.
// Purely combinational; reusable by any shared-resource arbiter.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!o_any && i_req[IDW'(w_j)]) begin
        o_any              = 1'b1;
        o_grant[IDW'(w_j)] = 1'b1;
        o_idx              = IDW'(w_j);
      end
    end
  end

endmodule

// File: rtl/ialu_rr_arbiter.sv
// Round-robin share of one external I-type ALU with a 1-entry result slot.
// Define IALU_ARB_PERF_EN to add per-requester grant and stall counters.
module ialu_rr_arbiter
  import riscv_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*3-1:0]  req_func,
  input  logic [NREQ-1:0]  req_alt,
  input  logic [NREQ*32-1:0] req_rv1,
  input  logic [NREQ*32-1:0] req_imm,
  output logic [2:0]       alu_func,
  output logic             alu_alt,
  output logic [31:0]      alu_rv1,
  output logic [31:0]      alu_imm,
  input  logic [31:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [31:0]      rsp_data
`ifdef IALU_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0] perf_grant_cnt,
  output logic [15:0]      perf_stall_cnt
`endif
);

  if (NREQ < 2 || NREQ > IALU_ARB_MAX_REQ) begin : g_bad_nreq
    $error("ialu_rr_arbiter: NREQ out of range");
  end

  slot_e           r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [31:0]     r_data;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_sel;
  logic [IDW-1:0]  w_next_ptr;
  logic            w_any;
  logic            w_free;
  logic            w_acc;
  i_func           w_func;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Ready depends only on slot state, rsp_ready and the request vector.
  assign w_free    = (r_state == SLOT_EMPTY) || rsp_ready;
  assign req_ready = (reset || !w_free) ? '0 : w_grant;
  assign w_acc     = w_any && w_free && !reset;

  // Idle mux parks on ptr so the ALU never sees an undriven selection.
  assign w_sel    = w_any ? w_idx : r_ptr;
  assign w_func   = i_func'(req_func[3*int'(w_sel) +: 3]);
  assign alu_func = w_func;
  assign alu_alt  = req_alt[w_sel];
  assign alu_rv1  = req_rv1[32*int'(w_sel) +: 32];
  assign alu_imm  = req_imm[32*int'(w_sel) +: 32];

  assign w_next_ptr = (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SLOT_EMPTY;
      r_ptr   <= '0;
      r_id    <= '0;
      r_data  <= '0;
    end else if (w_acc) begin
      r_state <= SLOT_FULL;
      r_ptr   <= w_next_ptr;
      r_id    <= w_idx;
      r_data  <= alu_result;
    end else if (rsp_ready) begin
      r_state <= SLOT_EMPTY;
    end
  end

  assign rsp_valid = (r_state == SLOT_FULL);
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;

`ifdef IALU_ARB_PERF_EN
  logic [15:0] r_gcnt [NREQ];
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREQ; k++) r_gcnt[k] <= '0;
      r_stall <= '0;
    end else begin
      if (w_acc) r_gcnt[w_idx] <= r_gcnt[w_idx] + 16'd1;
      if ((|req_valid) && !(|req_ready)) r_stall <= r_stall + 16'd1;
    end
  end

  for (genvar k = 0; k < NREQ; k++) begin : g_perf
    assign perf_grant_cnt[16*k +: 16] = r_gcnt[k];
  end
  assign perf_stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_ialu_rr_arbiter.sv
// Scoreboard bench for ialu_rr_arbiter: directed plan items plus random traffic.
// Reference model arbitrates from the round-robin rules and computes ALU results.
module tb_ialu_rr_arbiter;
  import riscv_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*3-1:0]    req_func;
  logic [NREQ-1:0]      req_alt;
  logic [NREQ*32-1:0]   req_rv1;
  logic [NREQ*32-1:0]   req_imm;
  logic [2:0]           alu_func;
  logic                 alu_alt;
  logic [31:0]          alu_rv1;
  logic [31:0]          alu_imm;
  logic [31:0]          alu_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data;
`ifdef IALU_ARB_PERF_EN
  logic [NREQ*16-1:0]   perf_grant_cnt;
  logic [15:0]          perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int   rsp_log[$];
  logic m_full = 1'b0;
  int   m_ptr = 0;
  int   m_wait[NREQ];
  logic [15:0] m_gcnt[NREQ];
  logic [15:0] m_stall = '0;

  always #5 clk = ~clk;

  ialu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func   (req_func),
    .req_alt    (req_alt),
    .req_rv1    (req_rv1),
    .req_imm    (req_imm),
    .alu_func   (alu_func),
    .alu_alt    (alu_alt),
    .alu_rv1    (alu_rv1),
    .alu_imm    (alu_imm),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
`ifdef IALU_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  function automatic logic [31:0] ialu(logic [2:0] f, logic a,
                                       logic [31:0] x, logic [31:0] im);
    logic [31:0] r;
    case (i_func'(f))
      ADDI:  r = x + im;
      SLTI:  r = ($signed(x) < $signed(im)) ? 32'd1 : 32'd0;
      SLTIU: r = (x < im) ? 32'd1 : 32'd0;
      XORI:  r = x ^ im;
      ORI:   r = x | im;
      ANDI:  r = x & im;
      SLLI:  r = x << im[4:0];
      default: r = a ? $unsigned($signed(x) >>> im[4:0]) : (x >> im[4:0]);
    endcase
    return r;
  endfunction

  // External shared ALU
  always_comb alu_result = ialu(alu_func, alu_alt, alu_rv1, alu_imm);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(int k, logic [2:0] f, logic a,
                         logic [31:0] x, logic [31:0] im);
    req_valid[k]         = 1'b1;
    req_func[3*k +: 3]   = f;
    req_alt[k]           = a;
    req_rv1[32*k +: 32]  = x;
    req_imm[32*k +: 32]  = im;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  always @(negedge clk) begin
    #1;
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, q.size() != 0});
    if (rsp_valid && q.size() != 0) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_data", rsp_data, q[0].data);
      if (rsp_ready) begin
        rsp_log.push_back(int'(rsp_id));
        void'(q.pop_front());
      end
    end
  end

  // Reference model: round-robin choice from the spec rules.
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    #2;
    if (reset) begin
      chk("ready_in_reset", 32'(req_ready), 32'd0);
      m_full = 1'b0;
      m_ptr  = 0;
      q.delete();
      m_stall = '0;
      for (int k = 0; k < NREQ; k++) begin
        m_gcnt[k] = '0;
        m_wait[k] = 0;
      end
    end else begin
      g = -1;
      for (int i = 0; i < NREQ; i++)
        if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
      exp_rdy = '0;
      if (g >= 0 && (!m_full || rsp_ready)) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_rdy != 0) begin
        q.push_back('{id: g, data: ialu(req_func[3*g +: 3], req_alt[g],
                                        req_rv1[32*g +: 32], req_imm[32*g +: 32])});
        m_full = 1'b1;
        m_ptr  = (g + 1) % NREQ;
        m_gcnt[g] = m_gcnt[g] + 16'd1;
        for (int k = 0; k < NREQ; k++) begin
          if (k == g || !req_valid[k]) m_wait[k] = 0;
          else m_wait[k]++;
          chk("fairness", 32'(m_wait[k] < NREQ), 32'd1);
        end
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end
      if (req_valid != 0 && exp_rdy == 0) m_stall = m_stall + 16'd1;
    end
  end

  initial begin
    int nb;
    logic [11:0] b;
    reset     = 1'b1;
    req_valid = '0;
    req_func  = '0;
    req_alt   = '0;
    req_rv1   = '0;
    req_imm   = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #3;
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_data", rsp_data, 32'd0);

    // ADDI single requester, one-cycle latency
    tick();
    set_req(0, ADDI, 1'b0, 32'd617, 32'd511);
    rsp_ready = 1'b1;
    #3 chk("t1_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    #3;
    chk("t1_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t1_id", 32'(rsp_id), 32'd0);
    chk("t1_data", rsp_data, 32'd1128);
    tick();

    // Two continuous requesters alternate with no bubbles
    do_reset();
    rsp_log.delete();
    rsp_ready = 1'b1;
    set_req(0, ADDI, 1'b0, 32'd5, 32'd7);
    set_req(1, ORI, 1'b0, 32'h00F0, 32'h000F);
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) req_valid = '0;
      #3 nb += int'(rsp_valid);
    end
    tick();
    tick();
    chk("t2_nobubble", 32'(nb), 32'd4);
    chk("t2_count", 32'(rsp_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", (rsp_log.size() > i) ? 32'(rsp_log[i]) : 32'hFFFF, 32'(i % 2));

    // SRAI vs SRLI on requester 1
    set_req(1, SRLI, 1'b1, 32'hFFFFFC4B, 32'd3);
    tick();
    req_alt[1] = 1'b0;
    #3;
    chk("t3_sra_id", 32'(rsp_id), 32'd1);
    chk("t3_sra", rsp_data, 32'hFFFFFF89);
    tick();
    req_valid = '0;
    #3 chk("t3_srl", rsp_data, 32'h1FFFFF89);

    // Backpressure with req0 waiting
    tick();
    set_req(0, XORI, 1'b0, 32'd679, 32'd91);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t4_hold", rsp_data, 32'h2FC);
      chk("t4_noready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #3;
    chk("t4_resume", 32'(req_ready), 32'd1);
    chk("t4_data", rsp_data, 32'h2FC);
    tick();
    req_valid = '0;

    // Reset while full; first grant afterwards goes to req0
    tick();
    rsp_ready = 1'b0;
    set_req(1, ADDI, 1'b0, 32'd1, 32'd2);
    tick();
    set_req(0, ANDI, 1'b0, 32'hFF, 32'h0F);
    reset = 1'b1;
    #3 chk("t5_rst_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    #3;
    chk("t5_dropped", {31'b0, rsp_valid}, 32'd0);
    chk("t5_first", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();

`ifdef IALU_ARB_PERF_EN
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, ADDI, 1'b0, 32'd1, 32'd1);
    repeat (3) tick();
    req_valid = 2'b00;
    set_req(1, ADDI, 1'b0, 32'd2, 32'd2);
    repeat (2) tick();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    repeat (4) tick();
    req_valid = '0;
    #3;
    chk("perf_grant", perf_grant_cnt, {16'd2, 16'd3});
    chk("perf_stall", 32'(perf_stall_cnt), 32'd4);
    do_reset();
    rsp_ready = 1'b1;
    #3;
    chk("perf_rst_grant", perf_grant_cnt, 32'd0);
    chk("perf_rst_stall", 32'(perf_stall_cnt), 32'd0);
`endif

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      tick();
      reset     = ($urandom_range(0, 60) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = '0;
      for (int k = 0; k < NREQ; k++) begin
        b = 12'($urandom);
        if ($urandom_range(0, 2) != 0)
          set_req(k, 3'($urandom), 1'($urandom), $urandom, {{20{b[11]}}, b});
      end
    end
    tick();
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    #3 chk("final_drain", 32'(q.size()), 32'd0);
`ifdef IALU_ARB_PERF_EN
    for (int k = 0; k < NREQ; k++)
      chk("perf_rand_grant", 32'(perf_grant_cnt[16*k +: 16]), 32'(m_gcnt[k]));
    chk("perf_rand_stall", 32'(perf_stall_cnt), 32'(m_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
